// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: read-mode selectors and count-width derivation.
package fifo_pkg;

   localparam bit StdMode  = 1'b0;
   localparam bit FwftMode = 1'b1;

   // One extra bit so the count can represent Depth itself.
   function automatic int count_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/shift_reg_fifo_store.sv
// Depth x Width shift storage: a write shifts din into entry 0, the read mux picks any entry.
module shift_reg_fifo_store #(
   parameter int Width     = 9,
   parameter int Depth     = 16,
   parameter int AddrWidth = $clog2(Depth)
) (
   input  logic                 clk_i,
   input  logic                 shift_en_i,
   input  logic [Width-1:0]     din_i,
   input  logic [AddrWidth-1:0] rd_idx_i,
   output logic [Width-1:0]     dout_o
);

   // No reset on the storage so it can map onto shift-register primitives.
   logic [Depth-1:0][Width-1:0] mem_q;

   always_ff @(posedge clk_i) begin
      if (shift_en_i) mem_q <= {mem_q[Depth-2:0], din_i};
   end

   assign dout_o = mem_q[rd_idx_i];

endmodule

// File: rtl/shift_reg_fifo.sv
// Parametrised shift-register FIFO with standard or first-word-fall-through read,
// handshake pulses, programmable thresholds and an exact data count.
module shift_reg_fifo
   import fifo_pkg::*;
#(
   parameter int Width          = 9,
   parameter int Depth          = 16,
   parameter bit Fwft           = StdMode,
   parameter int ProgFullValue  = 14,
   parameter int ProgEmptyValue = 5
) (
   input  logic                                clk_i,
   input  logic                                srst_n_i,
   input  logic [Width-1:0]                    din_i,
   input  logic                                wr_en_i,
   input  logic                                rd_en_i,
   output logic [Width-1:0]                    dout_o,
   output logic                                valid_o,
   output logic                                wr_ack_o,
   output logic                                overflow_o,
   output logic                                underflow_o,
   output logic                                full_o,
   output logic                                empty_o,
   output logic                                prog_full_o,
   output logic                                prog_empty_o,
   output logic [count_width(Depth)-1:0]       data_count_o
);

   localparam int CountWidth = count_width(Depth);
   localparam int AddrWidth  = $clog2(Depth);

   logic [CountWidth-1:0] count_q, count_d;
   logic                  full_q, empty_q, prog_full_q, prog_empty_q;
   logic                  wr_ack_q, overflow_q, underflow_q;
   logic                  wr_ok, rd_ok;
   logic [AddrWidth-1:0]  head_idx;
   logic [Width-1:0]      head_data;

   assign wr_ok   = wr_en_i & ~full_q;
   assign rd_ok   = rd_en_i & ~empty_q;
   assign count_d = count_q + CountWidth'(wr_ok) - CountWidth'(rd_ok);

   // Oldest word sits at entry count-1; a same-cycle read+write keeps that index.
   assign head_idx = count_q[AddrWidth-1:0] - AddrWidth'(1);

   shift_reg_fifo_store #(
      .Width     (Width),
      .Depth     (Depth),
      .AddrWidth (AddrWidth)
   ) u_store (
      .clk_i      (clk_i),
      .shift_en_i (wr_ok),
      .din_i      (din_i),
      .rd_idx_i   (head_idx),
      .dout_o     (head_data)
   );

   always_ff @(posedge clk_i) begin
      if (!srst_n_i) begin
         count_q      <= '0;
         full_q       <= 1'b0;
         empty_q      <= 1'b1;
         prog_full_q  <= 1'b0;
         prog_empty_q <= 1'b1;
         wr_ack_q     <= 1'b0;
         overflow_q   <= 1'b0;
         underflow_q  <= 1'b0;
      end else begin
         count_q      <= count_d;
         full_q       <= (count_d == CountWidth'(Depth));
         empty_q      <= (count_d == '0);
         prog_full_q  <= (count_d >= CountWidth'(ProgFullValue));
         prog_empty_q <= (count_d <= CountWidth'(ProgEmptyValue));
         wr_ack_q     <= wr_ok;
         overflow_q   <= wr_en_i & full_q;
         underflow_q  <= rd_en_i & empty_q;
      end
   end

   generate
      if (Fwft) begin : g_fwft
         assign dout_o  = head_data;
         assign valid_o = ~empty_q;
      end else begin : g_std
         logic [Width-1:0] dout_q;
         logic             valid_q;

         always_ff @(posedge clk_i) begin
            if (!srst_n_i) begin
               dout_q  <= '0;
               valid_q <= 1'b0;
            end else begin
               valid_q <= rd_ok;
               if (rd_ok) dout_q <= head_data;
            end
         end

         assign dout_o  = dout_q;
         assign valid_o = valid_q;
      end
   endgenerate

   assign wr_ack_o     = wr_ack_q;
   assign overflow_o   = overflow_q;
   assign underflow_o  = underflow_q;
   assign full_o       = full_q;
   assign empty_o      = empty_q;
   assign prog_full_o  = prog_full_q;
   assign prog_empty_o = prog_empty_q;
   assign data_count_o = count_q;

endmodule

// File: tb/tb_shift_reg_fifo.sv
// Scoreboard bench: a standard-mode 16x9 FIFO and an FWFT 4x32 FIFO, both checked
// against queue-based reference models.
module tb_shift_reg_fifo;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- standard mode DUT: Width 9, Depth 16 ----------------
   logic       s_rst_n = 1'b0, s_wr = 1'b0, s_rd = 1'b0;
   logic [8:0] s_din = '0, s_dout;
   logic       s_valid, s_ack, s_ovf, s_udf, s_full, s_empty, s_pf, s_pe;
   logic [4:0] s_cnt;

   shift_reg_fifo #(.Width(9), .Depth(16), .Fwft(1'b0), .ProgFullValue(14), .ProgEmptyValue(5)) u_std (
      .clk_i(clk), .srst_n_i(s_rst_n), .din_i(s_din), .wr_en_i(s_wr), .rd_en_i(s_rd),
      .dout_o(s_dout), .valid_o(s_valid), .wr_ack_o(s_ack), .overflow_o(s_ovf),
      .underflow_o(s_udf), .full_o(s_full), .empty_o(s_empty), .prog_full_o(s_pf),
      .prog_empty_o(s_pe), .data_count_o(s_cnt));

   logic [8:0] sq[$];       // reference contents, oldest first
   logic [8:0] s_sb[$];     // scoreboard of expected read data
   logic       s_live = 1'b0;
   logic       se_valid, se_ack, se_ovf, se_udf;
   logic [8:0] se_dout;

   always @(posedge clk) begin
      if (!s_rst_n) begin
         sq.delete(); s_sb.delete();
         se_valid = 0; se_ack = 0; se_ovf = 0; se_udf = 0; se_dout = '0;
         s_live = 1'b1;
      end else if (s_live) begin
         automatic bit fl  = (sq.size() == 16);
         automatic bit em  = (sq.size() == 0);
         automatic bit wok = s_wr && !fl;
         automatic bit rok = s_rd && !em;
         se_ack = wok; se_ovf = s_wr && fl; se_udf = s_rd && em; se_valid = rok;
         if (rok) begin se_dout = sq.pop_front(); s_sb.push_back(se_dout); end
         if (wok) sq.push_back(s_din);
      end
   end

   always @(negedge clk) begin
      if (s_live) begin
         chk("std_valid", s_valid, se_valid);
         chk("std_wr_ack", s_ack, se_ack);
         chk("std_overflow", s_ovf, se_ovf);
         chk("std_underflow", s_udf, se_udf);
         chk("std_count", s_cnt, sq.size());
         chk("std_full", s_full, sq.size() == 16);
         chk("std_empty", s_empty, sq.size() == 0);
         chk("std_prog_full", s_pf, sq.size() >= 14);
         chk("std_prog_empty", s_pe, sq.size() <= 5);
         if (s_valid) begin
            if (s_sb.size() == 0) chk("std_unexpected_valid", 1'b1, 1'b0);
            else chk("std_dout", s_dout, s_sb.pop_front());
         end else begin
            chk("std_dout_hold", s_dout, se_dout);
         end
      end
   end

   task automatic s_drive(input bit rn, input bit w, input bit r, input logic [8:0] d);
      @(posedge clk); #2;
      s_rst_n = rn; s_wr = w; s_rd = r; s_din = d;
   endtask

   task automatic s_seq();
      s_drive(0, 0, 0, 0); s_drive(0, 1, 1, 9'h55);
      s_drive(1, 0, 1, 0);                                   // read while empty
      for (int i = 1; i <= 16; i++) s_drive(1, 1, 0, 9'(i)); // fill
      s_drive(1, 1, 0, 9'h1FF); s_drive(1, 1, 0, 9'h1FE);    // overflow
      for (int i = 0; i < 18; i++) s_drive(1, 0, 1, 0);      // drain + underflow
      for (int i = 0; i < 5; i++) s_drive(1, 1, 0, 9'(9'h40 + i));
      for (int i = 0; i < 20; i++) s_drive(1, 1, 1, 9'($urandom));
      for (int i = 0; i < 5; i++) s_drive(1, 0, 1, 0);
      s_drive(1, 1, 1, 9'h0A5);                              // rd+wr at empty
      s_drive(1, 0, 0, 0);
      s_drive(1, 0, 1, 0);
      for (int i = 0; i < 16; i++) s_drive(1, 1, 0, 9'(9'h100 + i));
      s_drive(1, 1, 1, 9'h0EE);                              // rd+wr at full
      s_drive(1, 0, 0, 0);
      for (int i = 0; i < 16; i++) s_drive(1, 0, 1, 0);
      for (int i = 0; i < 10; i++) s_drive(1, 1, 0, 9'(9'h080 + i));
      s_drive(0, 1, 0, 9'h077);                              // reset mid-stream with wr_en
      s_drive(1, 1, 0, 9'h0AB);
      s_drive(1, 0, 1, 0);
      s_drive(1, 0, 0, 0);
      for (int blk = 0; blk < 10; blk++) begin
         automatic int pw = 20 + 7 * blk;
         automatic int pr = 85 - 7 * blk;
         for (int i = 0; i < 300; i++)
            s_drive(1, ($urandom % 100) < pw, ($urandom % 100) < pr, 9'($urandom));
      end
      for (int i = 0; i < 18; i++) s_drive(1, 0, 1, 0);
      s_drive(1, 0, 0, 0); s_drive(1, 0, 0, 0);
   endtask

   // ---------------- FWFT DUT: Width 32, Depth 4 ----------------
   logic        f_rst_n = 1'b0, f_wr = 1'b0, f_rd = 1'b0;
   logic [31:0] f_din = '0, f_dout;
   logic        f_valid, f_ack, f_ovf, f_udf, f_full, f_empty, f_pf, f_pe;
   logic [2:0]  f_cnt;

   shift_reg_fifo #(.Width(32), .Depth(4), .Fwft(1'b1), .ProgFullValue(3), .ProgEmptyValue(1)) u_fwft (
      .clk_i(clk), .srst_n_i(f_rst_n), .din_i(f_din), .wr_en_i(f_wr), .rd_en_i(f_rd),
      .dout_o(f_dout), .valid_o(f_valid), .wr_ack_o(f_ack), .overflow_o(f_ovf),
      .underflow_o(f_udf), .full_o(f_full), .empty_o(f_empty), .prog_full_o(f_pf),
      .prog_empty_o(f_pe), .data_count_o(f_cnt));

   logic [31:0] fq[$];
   logic        f_live = 1'b0;
   logic        fe_ack, fe_ovf, fe_udf;

   always @(posedge clk) begin
      if (!f_rst_n) begin
         fq.delete(); fe_ack = 0; fe_ovf = 0; fe_udf = 0; f_live = 1'b1;
      end else if (f_live) begin
         automatic bit fl  = (fq.size() == 4);
         automatic bit em  = (fq.size() == 0);
         automatic bit wok = f_wr && !fl;
         automatic bit rok = f_rd && !em;
         fe_ack = wok; fe_ovf = f_wr && fl; fe_udf = f_rd && em;
         if (rok) void'(fq.pop_front());
         if (wok) fq.push_back(f_din);
      end
   end

   always @(negedge clk) begin
      if (f_live) begin
         chk("fwft_valid", f_valid, fq.size() != 0);
         chk("fwft_wr_ack", f_ack, fe_ack);
         chk("fwft_overflow", f_ovf, fe_ovf);
         chk("fwft_underflow", f_udf, fe_udf);
         chk("fwft_count", f_cnt, fq.size());
         chk("fwft_full", f_full, fq.size() == 4);
         chk("fwft_empty", f_empty, fq.size() == 0);
         chk("fwft_prog_full", f_pf, fq.size() >= 3);
         chk("fwft_prog_empty", f_pe, fq.size() <= 1);
         if (f_valid && fq.size() != 0) chk("fwft_dout", f_dout, fq[0]);
      end
   end

   task automatic f_drive(input bit rn, input bit w, input bit r, input logic [31:0] d);
      @(posedge clk); #2;
      f_rst_n = rn; f_wr = w; f_rd = r; f_din = d;
   endtask

   task automatic f_seq();
      f_drive(0, 0, 0, 0);
      f_drive(1, 1, 0, 32'hDEADBEEF);
      f_drive(1, 0, 0, 0);                      // head presented without rd_en
      f_drive(1, 0, 1, 0);                      // pop it
      f_drive(1, 0, 0, 0);
      for (int i = 0; i < 6; i++) f_drive(1, 1, 0, $urandom);
      f_drive(1, 1, 1, 32'hCAFEF00D);
      for (int i = 0; i < 6; i++) f_drive(1, 0, 1, 0);
      for (int i = 0; i < 3; i++) f_drive(1, 1, 0, $urandom);
      f_drive(0, 1, 1, 32'h12345678);
      f_drive(1, 1, 0, 32'h0BADC0DE);
      f_drive(1, 0, 0, 0);
      for (int i = 0; i < 1500; i++)
         f_drive(1, ($urandom % 100) < 55, ($urandom % 100) < 50, $urandom);
      f_drive(1, 0, 0, 0);
   endtask

   initial begin
      fork
         s_seq();
         f_seq();
      join
      @(posedge clk); #2;
      chk("std_scoreboard_drained", s_sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
